// File: rtl/nand_gate_out_pipe.sv
// Multi-lane NAND/AND output stage: per-lane logic result registered into a
// small valid/ready FIFO with occupancy and transfer-count readouts.
module nand_gate_out_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WIDTH-1:0]     a,
  input  logic [LANES*WIDTH-1:0]     b,
  input  logic                       mode,
  input  logic [LANES-1:0]           lane_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*WIDTH-1:0]     y,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           xfer_cnt
);

  localparam int DW = LANES * WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [LW-1:0]    LVL_ZERO = '0;
  localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_out_valid;
  logic [DW-1:0]    r_y;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic             r_active;

  logic [DW-1:0]    w_din;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_rd_next;
  logic [LW-1:0]    w_level_next;
  logic [DW-1:0]    w_y_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_din = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_en[l]) begin
        w_din[l*WIDTH +: WIDTH] = mode ? (a[l*WIDTH +: WIDTH] & b[l*WIDTH +: WIDTH])
                                       : ~(a[l*WIDTH +: WIDTH] & b[l*WIDTH +: WIDTH]);
      end
    end
  end

  // r_active keeps in_ready low while in reset and until the first edge after it.
  assign in_ready  = r_active && (r_level != LVL_FULL);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = r_out_valid && out_ready;
  assign w_rd_next = r_rd_ptr + PTR_ONE;

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LVL_ONE;
      2'b01:   w_level_next = r_level - LVL_ONE;
      default: w_level_next = r_level;
    endcase
  end

  // The head is mirrored into r_y so y is a true register; when the FIFO
  // drains, r_y simply keeps the last head value.
  always_comb begin
    w_y_next = r_y;
    if (w_pop) begin
      if (r_level > LVL_ONE) begin
        w_y_next = r_mem[w_rd_next];
      end else if (w_push) begin
        w_y_next = w_din;
      end
    end else if ((r_level == LVL_ZERO) && w_push) begin
      w_y_next = w_din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_xfer_cnt  <= '0;
      r_active    <= 1'b0;
    end else begin
      r_active    <= 1'b1;
      r_level     <= w_level_next;
      r_out_valid <= (w_level_next != LVL_ZERO);
      r_y         <= w_y_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr   <= w_rd_next;
        r_xfer_cnt <= r_xfer_cnt + CNT_ONE;
      end
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and the visible output r_y is reset separately.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_din;
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign level     = r_level;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_nand_gate_out_pipe.sv
// Self-checking bench for nand_gate_out_pipe: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_nand_gate_out_pipe;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int D  = 2;
  localparam int C  = 4;
  localparam int DW = W * L;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          mode = 1'b0;
  logic [L-1:0]  lane_en = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] y;
  logic [1:0]    level;
  logic [C-1:0]  xfer_cnt;

  nand_gate_out_pipe #(.WIDTH(W), .LANES(L), .DEPTH(D), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .lane_en(lane_en), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .level(level), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] q[$];
  logic [31:0] m_y = '0;
  int          m_cnt = 0;
  bit          m_active = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each byte lane is the (N)AND of its operand bytes, or zero if masked.
  function automatic logic [31:0] ref_result(input logic [31:0] av, input logic [31:0] bv,
                                             input bit m, input logic [3:0] en);
    logic [31:0] r = 0;
    for (int l = 0; l < L; l++) begin
      int x = ((av >> (8 * l)) & 255) & ((bv >> (8 * l)) & 255);
      if (!m) x = 255 - x;
      if (en[l]) r = r | (32'(x) << (8 * l));
    end
    return r;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, ".level"}, 32'(level), 32'(q.size()));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(m_active && q.size() < D));
    check({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
    check({tag, ".y"}, y, m_y);
  endtask

  // One clock: drive inputs, predict the handshake, update the model, compare.
  task automatic cycle(input bit v, input logic [31:0] av, input logic [31:0] bv,
                       input bit m, input logic [3:0] en, input bit ordy, output bit acc);
    bit pop;
    in_valid = v; a = av; b = bv; mode = m; lane_en = en; out_ready = ordy;
    acc = v && m_active && (q.size() < D);
    pop = (q.size() > 0) && ordy;
    check("pre.in_ready", 32'(in_ready), 32'(m_active && q.size() < D));
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      m_cnt = (m_cnt + 1) % 16;
    end
    if (acc) q.push_back(ref_result(av, bv, m, en));
    if (q.size() > 0) m_y = q[0];
    m_active = 1;
    #1;
    compare_all("cyc");
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    cycle(0, 0, 0, 0, 0, ordy, acc);
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0;
    rst_n = 0;
    #1;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.level", 32'(level), 0);
    check("rst.in_ready", 32'(in_ready), 0);
    check("rst.xfer_cnt", 32'(xfer_cnt), 0);
    check("rst.y", y, 0);
    q.delete(); m_y = 0; m_cnt = 0; m_active = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst.in_ready_hold", 32'(in_ready), 0);
    @(posedge clk);
    m_active = 1;
    #1;
    compare_all("rst_exit");
  endtask

  initial begin
    bit          acc;
    int          budget;
    logic [31:0] start;
    bit          hv = 0;
    logic [31:0] ha = 0, hb = 0;
    bit          hm = 0;
    logic [3:0]  he = 0;

    #3;
    do_reset();

    // NAND on all lanes, then AND with a lane mask.
    cycle(1, 32'hFF00_F0AA, 32'hFFFF_0F55, 0, 4'hF, 1, acc);
    check("nand.y", y, 32'h00FF_FFFF);
    check("nand.valid", 32'(out_valid), 1);
    cycle(1, 32'hFF00_F0AA, 32'hFFFF_0F55, 1, 4'b0101, 1, acc);
    check("and_mask.y", y, 32'h0000_0000);
    cycle(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 4'b0101, 1, acc);
    check("and_ones.y", y, 32'h00FF_00FF);
    repeat (2) idle(1);

    // Backpressure: fill, hold the third beat, release one pop.
    cycle(1, 32'h1234_5678, 32'h0F0F_0F0F, 0, 4'hF, 0, acc);
    cycle(1, 32'hA5A5_A5A5, 32'h5A5A_FFFF, 1, 4'hF, 0, acc);
    cycle(1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 4'hF, 0, acc);
    check("bp.accepted3", 32'(acc), 0);
    check("bp.level", 32'(level), 2);
    check("bp.in_ready", 32'(in_ready), 0);
    cycle(1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 4'hF, 1, acc);
    check("bp.no_passthru", 32'(acc), 0);
    check("bp.head2", y, ref_result(32'hA5A5_A5A5, 32'h5A5A_FFFF, 1, 4'hF));
    budget = 5;
    do begin
      cycle(1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 4'hF, 0, acc);
      budget--;
    end while (!acc && budget > 0);
    if (!acc) check("bp.timeout", 0, 1);
    idle(1);
    check("bp.head3", y, ref_result(32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 4'hF));
    repeat (2) idle(1);

    // Simultaneous push+pop at level 1.
    cycle(1, $urandom, $urandom, 0, 4'hF, 0, acc);
    start = 32'(m_cnt);
    for (int i = 0; i < 10; i++) cycle(1, $urandom, $urandom, 1'($urandom), 4'($urandom), 1, acc);
    check("pp.level", 32'(level), 1);
    check("pp.cnt", 32'(xfer_cnt), (start + 10) % 16);
    idle(1);

    // Mid-stream reset with two entries held.
    cycle(1, $urandom, $urandom, 0, 4'hF, 0, acc);
    cycle(1, $urandom, $urandom, 0, 4'hF, 0, acc);
    check("mid.level", 32'(level), 2);
    @(negedge clk);
    do_reset();

    // Counter wrap: 17 transfers on a 4-bit counter.
    cycle(1, $urandom, $urandom, 0, 4'hF, 0, acc);
    for (int i = 0; i < 17; i++) cycle(1, $urandom, $urandom, 1'($urandom), 4'hF, 1, acc);
    check("wrap.cnt", 32'(xfer_cnt), 1);
    repeat (2) idle(1);

    // Random traffic; an unaccepted beat is held unchanged until taken.
    for (int i = 0; i < 400; i++) begin
      if (!hv) begin
        hv = 1'($urandom_range(0, 3) != 0);
        ha = $urandom; hb = $urandom; hm = 1'($urandom); he = 4'($urandom);
      end
      cycle(hv, ha, hb, hm, he, 1'($urandom_range(0, 2) != 0), acc);
      if (acc) hv = 0;
    end
    repeat (3) idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
